airplane_pos_ctrl: RTL

// Upstream of the VGA renderer: produces airplanex, the top row of the 10x100 px player bar drawn at x=30..40.

---
 rtl/airplane_pos_ctrl_pkg.sv | 23 ++
 rtl/airplane_pos_ctrl_button.sv | 47 ++++
 rtl/airplane_pos_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/airplane_pos_ctrl_pkg.sv
// Shared screen geometry and player-bar FSM codes.
// The VGA renderer also uses the geometry constants, so the bar limits below
// are derived from them rather than typed in separately.
package airplane_pos_ctrl_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int BORDER = 10;
  localparam int BAR_H  = 100;
  localparam int BAR_X0 = 30;
  localparam int BAR_X1 = 40;

  // The bar top row must stay inside the frame, clear of both borders.
  localparam int TOP_LIMIT_DEF    = BORDER;
  localparam int BOTTOM_LIMIT_DEF = V_RES - BORDER - BAR_H;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/airplane_pos_ctrl_button.sv
// button_debounce: 2-FF synchroniser followed by a stability counter.
// Ports:
//   clk_i   - system clock
//   rst_i   - async active-high reset
//   btn_i   - raw button, asynchronous to clk_i
//   level_o - debounced level; follows the synchronised button only after
//             it has disagreed for DEBOUNCE_CYCLES consecutive cycles
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Flip on the last cycle of the disagreement run; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/airplane_pos_ctrl.sv
// airplane_pos_ctrl: moves the player bar once per frame from debounced
// up/down buttons, ramping speed while a direction is held and clamping the
// bar top row to [TOP_LIMIT, BOTTOM_LIMIT].
// Ports:
//   clk, reset         - system clock, async active-high reset
//   btn_up, btn_down   - raw buttons, active high, asynchronous
//   vsync              - vertical retrace pulse; its rising edge is the frame tick
//   airplanex [9:0]    - bar top row
//   moving             - state is MOVE_UP or MOVE_DOWN
//   at_limit           - airplanex sits on a clamp limit
module airplane_pos_ctrl
  import airplane_pos_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int INIT_POS        = 190,
  parameter int TOP_LIMIT       = TOP_LIMIT_DEF,
  parameter int BOTTOM_LIMIT    = BOTTOM_LIMIT_DEF,
  parameter int MIN_STEP        = 2,
  parameter int MAX_STEP        = 8,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       vsync,
  output logic [9:0] airplanex,
  output logic       moving,
  output logic       at_limit
);

  // SW leaves headroom for step+1 before saturation.
  localparam int SW = $clog2(MAX_STEP + 2);
  localparam int CW = $clog2(ACCEL_FRAMES + 1);

  logic          up, dn, tick, vs_q;
  state_t        state_q, state_d;
  logic [9:0]    pos_q, pos_d;
  logic [SW-1:0] step_q, step_d, cur_step;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic          moving_q, moving_d, at_limit_q, at_limit_d;
  logic [10:0]   pos_x;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_i(clk), .rst_i(reset), .btn_i(btn_up), .level_o(up)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk_i(clk), .rst_i(reset), .btn_i(btn_down), .level_o(dn)
  );

  assign tick = vsync & ~vs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q       <= 1'b0;
      state_q    <= IDLE;
      pos_q      <= 10'(INIT_POS);
      step_q     <= SW'(MIN_STEP);
      cnt_q      <= '0;
      moving_q   <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      vs_q       <= vsync;
      state_q    <= state_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      moving_q   <= moving_d;
      at_limit_q <= at_limit_d;
    end
  end

  // Both buttons pressed is treated exactly like neither.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE:      state_d = (up & ~dn) ? MOVE_UP : (dn & ~up) ? MOVE_DOWN : IDLE;
        MOVE_UP:   state_d = (up & ~dn) ? MOVE_UP : (dn & ~up) ? MOVE_DOWN : IDLE;
        MOVE_DOWN: state_d = (dn & ~up) ? MOVE_DOWN : (up & ~dn) ? MOVE_UP : IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Entering a move or reversing restarts the ramp at MIN_STEP on that tick.
  always_comb begin
    pos_d      = pos_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    moving_d   = moving_q;
    at_limit_d = at_limit_q;
    cur_step   = (state_d == state_q) ? step_q : SW'(MIN_STEP);
    cnt_n      = ((state_d == state_q) ? cnt_q : '0) + CW'(1);
    pos_x      = {1'b0, pos_q};
    if (tick) begin
      moving_d = (state_d != IDLE);
      if (state_d == IDLE) begin
        step_d = SW'(MIN_STEP);
        cnt_d  = '0;
      end else begin
        if (state_d == MOVE_UP)
          pos_d = 10'((pos_x < 11'(TOP_LIMIT) + 11'(cur_step)) ? 11'(TOP_LIMIT)
                                                                : pos_x - 11'(cur_step));
        else
          pos_d = 10'((pos_x + 11'(cur_step) > 11'(BOTTOM_LIMIT)) ? 11'(BOTTOM_LIMIT)
                                                                   : pos_x + 11'(cur_step));
        if (cnt_n == CW'(ACCEL_FRAMES)) begin
          cnt_d  = '0;
          step_d = (cur_step >= SW'(MAX_STEP)) ? SW'(MAX_STEP) : cur_step + 1'b1;
        end else begin
          cnt_d  = cnt_n;
          step_d = cur_step;
        end
      end
      at_limit_d = (pos_d == 10'(TOP_LIMIT)) || (pos_d == 10'(BOTTOM_LIMIT));
    end
  end

  assign airplanex = pos_q;
  assign moving    = moving_q;
  assign at_limit  = at_limit_q;

endmodule
